// File: rtl/debounce_pkg.sv
// debounce_pkg: shared defaults and counter-width helper for the debounce bank
package debounce_pkg;
  localparam int DEF_NUM_CH = 4;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_STABLE_TICKS = 8;
  localparam int DEF_TICK_DIV = 1;
  localparam bit DEF_INIT_LEVEL = 1'b0;
  function automatic int cnt_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/debounce_bank_if.sv
// debounce_bank_if: raw inputs, enable and filtered outputs of the debounce bank
interface debounce_bank_if #(parameter int NUM_CH = 4);
  logic en;
  logic [NUM_CH-1:0] button;
  logic [NUM_CH-1:0] debounced;
  logic [NUM_CH-1:0] rise;
  logic [NUM_CH-1:0] fall;
  logic any_change;
  modport master (output en, button, input debounced, rise, fall, any_change);
  modport slave (input en, button, output debounced, rise, fall, any_change);
endinterface

// File: rtl/debounce_channel.sv
// debounce_channel: synchroniser, stability counter, filtered level and edge pulses for one input
module debounce_channel import debounce_pkg::*; #(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int STABLE_TICKS = DEF_STABLE_TICKS,
  parameter bit INIT_LEVEL = DEF_INIT_LEVEL
) (
  input  logic clk,
  input  logic reset,
  input  logic tick_i,
  input  logic button_i,
  output logic debounced_o,
  output logic rise_o,
  output logic fall_o,
  output logic toggle_o
);
  localparam int CW = cnt_width(STABLE_TICKS);
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic deb_q, deb_d, rise_q, rise_d, fall_q, fall_d, differ;
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], button_i};
    differ = sync_q[SYNC_STAGES-1] ^ deb_q;
    toggle_o = tick_i && differ && cnt_q == CW'(STABLE_TICKS - 1);
    cnt_d = !tick_i ? cnt_q : (differ && !toggle_o) ? cnt_q + 1'b1 : '0;
    deb_d = deb_q ^ toggle_o;
    rise_d = toggle_o && !deb_q;
    fall_d = toggle_o && deb_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= {SYNC_STAGES{INIT_LEVEL}};
      cnt_q <= '0;
      deb_q <= INIT_LEVEL;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      cnt_q <= cnt_d;
      deb_q <= deb_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end
  assign debounced_o = deb_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;
endmodule

// File: rtl/debounce_bank.sv
// debounce_bank: NUM_CH independent debouncers sharing one sample-tick prescaler
module debounce_bank import debounce_pkg::*; #(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int STABLE_TICKS = DEF_STABLE_TICKS,
  parameter int TICK_DIV = DEF_TICK_DIV,
  parameter bit INIT_LEVEL = DEF_INIT_LEVEL
) (
  input logic clk,
  input logic reset,
  debounce_bank_if.slave bus
);
  localparam int PW = cnt_width(TICK_DIV);
  logic [PW-1:0] pre_q, pre_d;
  logic tick, any_q, any_d;
  logic [NUM_CH-1:0] toggle, deb, rise, fall;
  always_comb begin
    tick = bus.en && pre_q == PW'(TICK_DIV - 1);
    pre_d = !bus.en ? pre_q : tick ? '0 : pre_q + 1'b1;
    any_d = |toggle;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      pre_q <= '0;
      any_q <= 1'b0;
    end else begin
      pre_q <= pre_d;
      any_q <= any_d;
    end
  end
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    debounce_channel #(
      .SYNC_STAGES(SYNC_STAGES),
      .STABLE_TICKS(STABLE_TICKS),
      .INIT_LEVEL(INIT_LEVEL)
    ) u_ch (
      .clk(clk),
      .reset(reset),
      .tick_i(tick),
      .button_i(bus.button[i]),
      .debounced_o(deb[i]),
      .rise_o(rise[i]),
      .fall_o(fall[i]),
      .toggle_o(toggle[i])
    );
  end
  assign bus.debounced = deb;
  assign bus.rise = rise;
  assign bus.fall = fall;
  assign bus.any_change = any_q;
endmodule

// File: tb/tb_debounce_bank.sv
// tb_debounce_bank: three bank configurations checked against a sample-history model plus literal expectations
module tb_debounce_bank;
  localparam int SS[3] = '{2, 2, 2};
  localparam int ST[3] = '{8, 3, 8};
  localparam int TD[3] = '{1, 4, 1};
  localparam bit IL[3] = '{1'b0, 1'b0, 1'b1};
  logic clk, reset;
  logic [3:0] btn[3];
  logic en_v[3];
  logic [3:0] dv[3], rv[3], fv[3];
  logic av[3];
  logic [7:0] pipe[3][4];
  logic [31:0] sh[3][4];
  int ns[3][4];
  logic [3:0] mlev[3], mr[3], mf[3];
  logic ma[3];
  int pc[3];
  int cyc, tests, fails, rc;
  bit started;
  logic [3:0] tbl[8];
  debounce_bank_if #(.NUM_CH(4)) if0 ();
  debounce_bank_if #(.NUM_CH(4)) if1 ();
  debounce_bank_if #(.NUM_CH(4)) if2 ();
  debounce_bank #(.NUM_CH(4), .SYNC_STAGES(2), .STABLE_TICKS(8), .TICK_DIV(1), .INIT_LEVEL(1'b0))
    u0 (.clk(clk), .reset(reset), .bus(if0));
  debounce_bank #(.NUM_CH(4), .SYNC_STAGES(2), .STABLE_TICKS(3), .TICK_DIV(4), .INIT_LEVEL(1'b0))
    u1 (.clk(clk), .reset(reset), .bus(if1));
  debounce_bank #(.NUM_CH(4), .SYNC_STAGES(2), .STABLE_TICKS(8), .TICK_DIV(1), .INIT_LEVEL(1'b1))
    u2 (.clk(clk), .reset(reset), .bus(if2));
  assign if0.en = en_v[0];
  assign if1.en = en_v[1];
  assign if2.en = en_v[2];
  assign if0.button = btn[0];
  assign if1.button = btn[1];
  assign if2.button = btn[2];
  assign dv[0] = if0.debounced;
  assign dv[1] = if1.debounced;
  assign dv[2] = if2.debounced;
  assign rv[0] = if0.rise;
  assign rv[1] = if1.rise;
  assign rv[2] = if2.rise;
  assign fv[0] = if0.fall;
  assign fv[1] = if1.fall;
  assign fv[2] = if2.fall;
  assign av[0] = if0.any_change;
  assign av[1] = if1.any_change;
  assign av[2] = if2.any_change;
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial forever begin
    logic s, tk;
    logic [31:0] mask;
    @(posedge clk);
    for (int d = 0; d < 3; d++) begin
      if (reset) begin
        pc[d] = 0;
        mlev[d] = {4{IL[d]}};
        mr[d] = '0;
        mf[d] = '0;
        ma[d] = 1'b0;
        for (int c = 0; c < 4; c++) begin
          pipe[d][c] = {8{IL[d]}};
          sh[d][c] = '0;
          ns[d][c] = 0;
        end
      end else begin
        tk = en_v[d] && (pc[d] % TD[d] == TD[d] - 1);
        if (en_v[d]) pc[d]++;
        mr[d] = '0;
        mf[d] = '0;
        mask = (32'd1 << ST[d]) - 32'd1;
        for (int c = 0; c < 4; c++) begin
          s = pipe[d][c][SS[d]-1];
          pipe[d][c] = {pipe[d][c][6:0], btn[d][c]};
          if (tk) begin
            sh[d][c] = {sh[d][c][30:0], s};
            ns[d][c]++;
            if (ns[d][c] >= ST[d] && (sh[d][c] & mask) == (mlev[d][c] ? 32'd0 : mask)) begin
              mr[d][c] = !mlev[d][c];
              mf[d][c] = mlev[d][c];
              mlev[d][c] = !mlev[d][c];
            end
          end
        end
        ma[d] = |(mr[d] | mf[d]);
      end
    end
    if (reset) cyc = 0;
    else cyc++;
    started = 1'b1;
  end
  always @(negedge clk) begin
    if (started) begin
      for (int d = 0; d < 3; d++) begin
        tests++;
        if ({dv[d], rv[d], fv[d], av[d]} !== {mlev[d], mr[d], mf[d], ma[d]}) begin
          fails++;
          $display("FAIL model inst%0d cyc%0d: deb/rise/fall/any got %h/%h/%h/%b want %h/%h/%h/%b",
                   d, cyc, dv[d], rv[d], fv[d], av[d], mlev[d], mr[d], mf[d], ma[d]);
        end
      end
      if (rv[1][2] === 1'b1) rc++;
    end
  end
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", name, got, exp);
    end
  endtask
  task automatic wait_cyc(input int c);
    int g = 0;
    while (cyc < c && g < 1000) begin
      @(negedge clk);
      g++;
    end
    if (cyc != c) begin
      fails++;
      $display("FAIL wait_cyc: reached %0d want %0d", cyc, c);
    end
  endtask
  initial begin
    tbl = '{4'h0, 4'h3, 4'h3, 4'hC, 4'hF, 4'hF, 4'h5, 4'h5};
    reset = 1'b1;
    en_v = '{1'b1, 1'b1, 1'b1};
    btn[0] = 4'h0;
    btn[1] = 4'h0;
    btn[2] = 4'hF;
    repeat (3) @(negedge clk);
    chk("rst_deb0", 32'(dv[0]), 32'h0);
    chk("rst_pulse0", 32'({rv[0], fv[0], av[0]}), 32'h0);
    chk("rst_deb2", 32'(dv[2]), 32'hF);
    reset = 1'b0;
    wait_cyc(10);
    btn[0] = 4'b0001;
    btn[1] = 4'b0100;
    wait_cyc(19);
    chk("lat_deb0_c19", 32'(dv[0]), 32'h0);
    wait_cyc(20);
    chk("lat_deb0_c20", 32'(dv[0]), 32'h1);
    chk("lat_rise0_c20", 32'(rv[0]), 32'h1);
    chk("lat_any0_c20", 32'(av[0]), 32'h1);
    wait_cyc(21);
    chk("lat_rise0_c21", 32'({rv[0], av[0]}), 32'h0);
    chk("init1_deb2", 32'(dv[2]), 32'hF);
    chk("init1_pulse2", 32'({rv[2], fv[2], av[2]}), 32'h0);
    wait_cyc(23);
    chk("div_deb1_c23", 32'(dv[1]), 32'h0);
    wait_cyc(24);
    chk("div_deb1_c24", 32'(dv[1]), 32'h4);
    chk("div_rise1_c24", 32'(rv[1]), 32'h4);
    wait_cyc(25);
    chk("div_rise1_c25", 32'(rv[1]), 32'h0);
    for (int k = 0; k < 5; k++) begin
      wait_cyc(30 + 10 * k);
      btn[0][1] = 1'b1;
      wait_cyc(35 + 10 * k);
      btn[0][1] = 1'b0;
    end
    wait_cyc(80);
    chk("glitch_deb0", 32'(dv[0]), 32'h1);
    wait_cyc(90);
    btn[0] = 4'h0;
    wait_cyc(100);
    chk("fall0_c100", 32'({dv[0], fv[0]}), 32'h01);
    wait_cyc(110);
    btn[0] = 4'hF;
    wait_cyc(120);
    chk("all_rise0", 32'({dv[0], rv[0], av[0]}), 32'h1FF);
    wait_cyc(121);
    chk("all_rise0_end", 32'({rv[0], av[0]}), 32'h0);
    wait_cyc(130);
    btn[0] = 4'h0;
    wait_cyc(140);
    chk("all_fall0", 32'(fv[0]), 32'hF);
    chk("rise1_count", 32'(rc), 32'd1);
    wait_cyc(150);
    btn[0] = 4'hF;
    wait_cyc(157);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_deb0", 32'(dv[0]), 32'h0);
    chk("midrst_pulse0", 32'({rv[0], fv[0], av[0]}), 32'h0);
    chk("midrst_inst1", 32'({dv[1], rv[1], fv[1], av[1]}), 32'h0);
    chk("midrst_deb2", 32'(dv[2]), 32'hF);
    reset = 1'b0;
    wait_cyc(9);
    chk("requal_deb0_c9", 32'(dv[0]), 32'h0);
    wait_cyc(10);
    chk("requal_deb0_c10", 32'({dv[0], rv[0]}), 32'hFF);
    for (int i = 0; i < 40; i++) begin
      wait_cyc(20 + 6 * i);
      for (int d = 0; d < 3; d++) begin
        btn[d] = tbl[(i + d) % 8];
        en_v[d] = ((i + d) % 5) != 4;
      end
    end
    wait_cyc(290);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/debounce_bank.md
DEBOUNCE_BANK -- requirements
Module: debounce_bank

Interface
REQ-001 Parameter NUM_CH, 4, number of independent input channels (>=1).
REQ-002 Parameter SYNC_STAGES, 2, synchroniser flops per channel (>=2).
REQ-003 Parameter STABLE_TICKS, 8, consecutive differing samples required to accept a new level (>=1).
REQ-004 Parameter TICK_DIV, 1, clk cycles per sample tick (>=1; 1 = sample every cycle).
REQ-005 Parameter INIT_LEVEL, 0, 1-bit reset level of synchronisers and debounced outputs.
REQ-006 clk  input  1  clock; all state updates on its rising edge.
REQ-007 reset  input  1  reset, synchronous, active-high.
REQ-008 en  input  1  sampling enable; low freezes prescaler and channel counters.
REQ-009 button  input  NUM_CH  raw asynchronous, bouncy inputs.
REQ-010 debounced  output  NUM_CH  registered filtered levels.
REQ-011 rise  output  NUM_CH  one-cycle pulse when debounced[i] goes 0->1.
REQ-012 fall  output  NUM_CH  one-cycle pulse when debounced[i] goes 1->0.
REQ-013 any_change  output  1  registered OR of rise|fall, coincident with them.

Function
REQ-014 Each button[i] SHALL pass through a SYNC_STAGES-deep flop chain; only the last stage (sync[i]) feeds the filter.
REQ-015 A shared prescaler SHALL count 0..TICK_DIV-1 while en=1, wrap to 0, and assert tick in the cycle its value equals TICK_DIV-1; TICK_DIV=1 gives tick=en every cycle.
REQ-016 On tick, if sync[i]==debounced[i], channel counter cnt[i] SHALL clear to 0.
REQ-017 On tick, if sync[i]!=debounced[i] and cnt[i]<STABLE_TICKS-1, cnt[i] SHALL increment.
REQ-018 On tick, if sync[i]!=debounced[i] and cnt[i]==STABLE_TICKS-1, debounced[i] SHALL toggle, cnt[i] clear, and rise[i] or fall[i] assert for exactly that following cycle.
REQ-019 A single matching sample SHALL restart qualification (glitch shorter than STABLE_TICKS ticks never propagates).
REQ-020 Without tick, cnt[i] and debounced[i] SHALL hold and rise/fall SHALL be 0.
REQ-021 Latency with TICK_DIV=1, en=1: clean input edge reaches debounced after SYNC_STAGES+STABLE_TICKS clk cycles.
REQ-022 cnt width SHALL be clog2(STABLE_TICKS) bits (min 1); it SHALL never exceed STABLE_TICKS-1.
REQ-023 Channels SHALL be fully independent; simultaneous transitions on several channels SHALL each pulse in the same cycle.
REQ-024 rise[i] and fall[i] SHALL never be asserted together.

Reset
REQ-025 While reset=1: sync chains and debounced = INIT_LEVEL replicated, cnt=0, prescaler=0, rise=fall=0, any_change=0.
REQ-026 Reset SHALL override en and tick in the same cycle; reset mid-qualification SHALL discard partial counts with no pulse.
REQ-027 First cycle after reset SHALL produce no rise/fall regardless of button level until full qualification.

Structure
REQ-028 Shared package debounce_pkg SHALL hold parameter defaults and a clog2-based counter-width function.
REQ-029 Per-channel logic SHALL be a sub-module debounce_channel (sync chain, counter, level, pulses), instantiated NUM_CH times by generate; prescaler and any_change live in the top.

Verification
REQ-030 Defaults, button[0] 0->1 clean at cycle 10 -> debounced[0]=1 and rise[0] pulse at cycle 20, other channels 0.
REQ-031 Defaults, button[1] high for 5 cycles then low, repeated -> debounced[1] stays 0, no pulses.
REQ-032 TICK_DIV=4, STABLE_TICKS=3, button[2] 0->1 held -> debounced[2] rises within 2+12 cycles, exactly one rise[2].
REQ-033 button[3:0] all rise same cycle -> rise=4'hF and any_change=1 for one cycle together.
REQ-034 reset asserted at cnt[0]=5 mid-qualification -> all outputs 0 next cycle, requalification restarts from 0 after release.
REQ-035 INIT_LEVEL=1, button held 1 through reset release -> debounced=all ones, no fall/rise pulses.
